// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the memory stage and the
// responder: a request handshake and a response handshake, both valid/ready.
interface data_mem_responder_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespRData;
    logic        RespErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, RespReady,
        input  ReqReady, RespValid, RespRData, RespErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, RespReady,
        output ReqReady, RespValid, RespRData, RespErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with programmable wait-states behind a
// valid/ready request/response pair. Optional macro: MEM_RESP_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    data_mem_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
        $error("WAIT_CYCLES must be within 0..15");
    end

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    stateT                  state;
    logic [3:0]             cnt;
    logic                   reqWrite;
    logic [ADDR_WIDTH-1:0]  reqIdx;
    logic [31:0]            reqWData;
    logic                   reqMis;
    logic                   respValid;
    logic [31:0]            respRData;
    logic                   respErr;

    logic                   accept;
    logic                   doAccess;
    logic                   misIn;
    logic                   accWrite;
    logic [ADDR_WIDTH-1:0]  accIdx;
    logic [31:0]            accWData;
    logic                   accMis;
    logic                   unusedAddr;

    assign bus.ReqReady  = (state == IDLE) && !rst;
    assign bus.RespValid = respValid;
    assign bus.RespRData = respRData;
    assign bus.RespErr   = respErr;

    assign accept = bus.ReqValid && bus.ReqReady;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign misIn = (bus.ReqAddr[1:0] != 2'b00);
`else
    assign misIn = 1'b0;
`endif

    // Upper bits alias; byte offset only matters for the alignment check.
    assign unusedAddr = ^{bus.ReqAddr[31:ADDR_WIDTH+2], bus.ReqAddr[1:0]};

    // With no wait-states the access uses the live request; otherwise the captured one.
    always_comb begin
        accWrite = reqWrite;
        accIdx   = reqIdx;
        accWData = reqWData;
        accMis   = reqMis;
        if (state == IDLE) begin
            accWrite = bus.ReqWrite;
            accIdx   = bus.ReqAddr[ADDR_WIDTH+1:2];
            accWData = bus.ReqWData;
            accMis   = misIn;
        end
    end

    assign doAccess = (WAIT_CYCLES == 0) ? (state == IDLE && accept)
                                         : (state == WAIT && cnt == 4'd0);

    // Request/response FSM; storage commit and response registers in one place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            reqWrite  <= 1'b0;
            reqIdx    <= '0;
            reqWData  <= 32'h0;
            reqMis    <= 1'b0;
            respValid <= 1'b0;
            respRData <= 32'h0;
            respErr   <= 1'b0;
        end else begin
            if (doAccess) begin
                respErr <= accMis;
                if (accMis) begin
                    respRData <= 32'h0;
                end else if (accWrite) begin
                    mem[accIdx] <= accWData;
                    respRData   <= 32'h0;
                end else begin
                    respRData <= mem[accIdx];
                end
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        reqWrite <= bus.ReqWrite;
                        reqIdx   <= bus.ReqAddr[ADDR_WIDTH+1:2];
                        reqWData <= bus.ReqWData;
                        reqMis   <= misIn;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            cnt   <= WAIT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!respValid) begin
                        respValid <= 1'b1;
                    end else if (bus.RespReady) begin
                        respValid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
